// File: rtl/alu_exec.sv
// Execution unit behind alu_control: single-cycle ADD/SUB/AND/OR and an iterative
// radix-2 shift-add multiplier, with a registered result and a start/done handshake.
module alu_exec #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ctrl_command,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_MUL_RUN = 1'b1
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic [WIDTH-1:0] acc_lo_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_hi_q;
   logic             zero_q;
   logic             overflow_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] add_sum;
   logic [WIDTH-1:0] sub_diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic [WIDTH-1:0] alu_res_d;
   logic             alu_ovf_d;
   logic [WIDTH:0]   partial_d;
   logic [WIDTH-1:0] acc_hi_d;
   logic [WIDTH-1:0] acc_lo_d;

   // Single-cycle datapath; unlisted opcodes fall through to ADD.
   always_comb begin
      add_sum  = operand_a + operand_b;
      sub_diff = operand_a - operand_b;
      add_ovf  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                 (add_sum[WIDTH-1] != operand_a[WIDTH-1]);
      sub_ovf  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                 (sub_diff[WIDTH-1] != operand_a[WIDTH-1]);
      alu_res_d = add_sum;
      alu_ovf_d = add_ovf;
      case (ctrl_command)
         OP_ADD: begin
            alu_res_d = add_sum;
            alu_ovf_d = add_ovf;
         end
         OP_SUB: begin
            alu_res_d = sub_diff;
            alu_ovf_d = sub_ovf;
         end
         OP_AND: begin
            alu_res_d = operand_a & operand_b;
            alu_ovf_d = 1'b0;
         end
         OP_OR: begin
            alu_res_d = operand_a | operand_b;
            alu_ovf_d = 1'b0;
         end
         default: begin
            alu_res_d = add_sum;
            alu_ovf_d = add_ovf;
         end
      endcase
   end

   // One multiplier iteration: the multiplier sits in acc_lo and is consumed LSB first
   // while product bits shift in from the top, so {acc_hi,acc_lo} ends as the product.
   always_comb begin
      partial_d = {1'b0, acc_hi_q};
      if (acc_lo_q[0]) begin
         partial_d = {1'b0, acc_hi_q} + {1'b0, mcand_q};
      end
      acc_hi_d = partial_d[WIDTH:1];
      acc_lo_d = {partial_d[0], acc_lo_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         mcand_q     <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (ctrl_command == OP_MUL) begin
                     mcand_q  <= operand_a;
                     acc_lo_q <= operand_b;
                     acc_hi_q <= '0;
                     count_q  <= CNT_W'(WIDTH);
                     busy_q   <= 1'b1;
                     state_q  <= S_MUL_RUN;
                  end else begin
                     result_q    <= alu_res_d;
                     result_hi_q <= '0;
                     zero_q      <= (alu_res_d == '0);
                     overflow_q  <= alu_ovf_d;
                     done_q      <= 1'b1;
                  end
               end
            end
            S_MUL_RUN: begin
               acc_hi_q <= acc_hi_d;
               acc_lo_q <= acc_lo_d;
               count_q  <= count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  result_q    <= acc_lo_d;
                  result_hi_q <= acc_hi_d;
                  zero_q      <= (acc_lo_d == '0);
                  overflow_q  <= 1'b0;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec (WIDTH=32): single-cycle ops, flags, multiply timing,
// ignored mid-run starts, back-to-back issue and reset abort.
module tb_alu_exec;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [3:0]    ctrl_command;
   logic [W-1:0]  operand_a;
   logic [W-1:0]  operand_b;
   logic [W-1:0]  result;
   logic [W-1:0]  result_hi;
   logic          zero;
   logic          overflow;
   logic          busy;
   logic          done;

   int checks = 0;
   int passed = 0;
   int done_seen;

   alu_exec #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .ctrl_command (ctrl_command),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .result       (result),
      .result_hi    (result_hi),
      .zero         (zero),
      .overflow     (overflow),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
         $display("check %-16s obs=%h exp=%h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
      start        = 1'b1;
      ctrl_command = cmd;
      operand_a    = a;
      operand_b    = b;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      ctrl_command = 4'd0;
      operand_a    = '0;
      operand_b    = '0;
      repeat (2) @(negedge clk);
      check("reset_outs", {result, result_hi}, 64'h0);
      check("reset_flags", {60'h0, zero, overflow, busy, done}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD with signed overflow
      issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
      check("add_result", {32'h0, result}, {32'h0, 32'h8000_0000});
      check("add_flags", {60'h0, zero, overflow, busy, done}, {60'h0, 4'b0101});
      check("add_hi", {32'h0, result_hi}, 64'h0);
      @(negedge clk);
      check("add_done_drop", {63'h0, done}, 64'h0);

      // SUB to zero, AND, OR
      issue(4'd1, 32'd5, 32'd5);
      check("sub_result", {32'h0, result}, 64'h0);
      check("sub_flags", {60'h0, zero, overflow, busy, done}, {60'h0, 4'b1001});
      @(negedge clk);
      issue(4'd3, 32'h0000_F0F0, 32'h0000_FF00);
      check("and_result", {32'h0, result}, {32'h0, 32'h0000_F000});
      @(negedge clk);
      issue(4'd4, 32'h0000_F0F0, 32'h0000_FF00);
      check("or_result", {32'h0, result}, {32'h0, 32'h0000_FFF0});
      check("or_flags", {60'h0, zero, overflow, busy, done}, {60'h0, 4'b0001});
      @(negedge clk);

      // MUL all-ones squared, with ignored start pulses mid-run
      issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mul_e0_bd", {62'h0, busy, done}, {62'h0, 2'b10});
      done_seen = 0;
      for (int k = 1; k < W; k++) begin
         if (k == 5) begin
            start = 1'b1; ctrl_command = 4'd0; operand_a = 32'd1; operand_b = 32'd1;
         end
         if (k == 8) start = 1'b0;
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b1 || result !== 32'h0000_FFF0) done_seen++;
      end
      check("mul_run_hold", done_seen, 64'h0);
      @(negedge clk);
      check("mul_done_e32", {62'h0, busy, done}, {62'h0, 2'b01});
      check("mul_product", {result_hi, result}, 64'hFFFF_FFFE_0000_0001);
      check("mul_flags", {62'h0, zero, overflow}, 64'h0);
      @(negedge clk);
      check("mul_done_drop", {63'h0, done}, 64'h0);

      // Unlisted opcode executes as ADD, then MUL issued in the done cycle
      issue(4'hF, 32'd3, 32'd4);
      check("dflt_add", {32'h0, result}, 64'd7);
      check("dflt_done", {63'h0, done}, 64'h1);
      issue(4'd2, 32'd7, 32'd6);
      done_seen = 0;
      for (int k = 1; k < W; k++) begin
         @(negedge clk);
         if (done !== 1'b0) done_seen++;
      end
      check("b2b_no_early", done_seen, 64'h0);
      @(negedge clk);
      check("b2b_done", {63'h0, done}, 64'h1);
      check("b2b_product", {result_hi, result}, 64'd42);

      // Reset during multiply aborts it
      @(negedge clk);
      issue(4'd2, 32'h0000_1234, 32'h0000_0010);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_outs", {result, result_hi}, 64'h0);
      check("abort_flags", {60'h0, zero, overflow, busy, done}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      end
      check("abort_quiet", done_seen, 64'h0);
      issue(4'd0, 32'd1, 32'd1);
      check("post_abort_add", {32'h0, result}, 64'd2);
      check("post_abort_done", {63'h0, done}, 64'h1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
